// File: rtl/multi_edge_event_sync.sv
// Multi-channel event synchroniser: each asynchronous input passes through a
// flop chain, edges are detected per EdgeMode and queued in a saturating
// per-channel pending counter that the consumer drains one event per ready.
module multi_edge_event_sync #(
  parameter int unsigned NumCh      = 4,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned CntWidth   = 3,
  parameter int unsigned EdgeMode   = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic [NumCh-1:0]          async_i,
  output logic [NumCh-1:0]          sync_o,
  output logic [NumCh-1:0]          evt_valid_o,
  input  logic [NumCh-1:0]          evt_ready_i,
  output logic [NumCh*CntWidth-1:0] pending_o,
  output logic [NumCh-1:0]          overflow_o
);

  localparam logic [CntWidth-1:0] CntMax = '1;
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    logic [SyncStages-1:0] chain_q;
    logic                  prev_q;
    logic                  evt;
    logic                  pop;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;

    // Synchroniser chain; stage 0 samples the asynchronous input, no logic between stages.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        chain_q <= '0;
      end else begin
        chain_q <= {chain_q[SyncStages-2:0], async_i[c]};
      end
    end

    assign sync_o[c] = chain_q[SyncStages-1];

    // Edge history: last cycle's synchronised level (updates even during clear).
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prev_q <= 1'b0;
      end else begin
        prev_q <= sync_o[c];
      end
    end

    if (EdgeMode == 1) begin : g_rise
      assign evt = sync_o[c] & ~prev_q;
    end else if (EdgeMode == 2) begin : g_fall
      assign evt = ~sync_o[c] & prev_q;
    end else begin : g_both
      assign evt = sync_o[c] ^ prev_q;
    end

    // Pop only counts when an event is actually pending, so the counter never underflows.
    assign pop = evt_ready_i[c] & (cnt_q != '0);

    // Pending counter next state: clear, then event+pop, then event, then pop.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clear_i) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (evt && pop) begin
        cnt_d = cnt_q;
      end else if (evt) begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end else begin
          ovf_d = 1'b1;
        end
      end else if (pop) begin
        cnt_d = cnt_q - CntOne;
      end
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign evt_valid_o[c]                        = |cnt_q;
    assign pending_o[c*CntWidth +: CntWidth]     = cnt_q;
    assign overflow_o[c]                         = ovf_q;
  end

endmodule

// File: tb/tb_multi_edge_event_sync.sv
// Directed self-checking bench for multi_edge_event_sync (4 channels, 2 sync
// stages, 3-bit counters); a mode-0 DUT plus rising-only and falling-only copies.
module tb_multi_edge_event_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [3:0]  async_in;
  logic [3:0]  ready;
  logic [3:0]  sync_out, valid, ovf;
  logic [11:0] pend;

  logic [3:0]  async_m;
  logic [3:0]  m1_sync, m1_valid, m1_ovf;
  logic [11:0] m1_pend;
  logic [3:0]  m2_sync, m2_valid, m2_ovf;
  logic [11:0] m2_pend;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  multi_edge_event_sync #(.NumCh(4), .SyncStages(2), .CntWidth(3), .EdgeMode(0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .async_i(async_in), .sync_o(sync_out),
    .evt_valid_o(valid), .evt_ready_i(ready), .pending_o(pend), .overflow_o(ovf)
  );

  multi_edge_event_sync #(.NumCh(4), .SyncStages(2), .CntWidth(3), .EdgeMode(1)) u_m1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(1'b0), .async_i(async_m), .sync_o(m1_sync),
    .evt_valid_o(m1_valid), .evt_ready_i(4'b0000), .pending_o(m1_pend), .overflow_o(m1_ovf)
  );

  multi_edge_event_sync #(.NumCh(4), .SyncStages(2), .CntWidth(3), .EdgeMode(2)) u_m2 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(1'b0), .async_i(async_m), .sync_o(m2_sync),
    .evt_valid_o(m2_valid), .evt_ready_i(4'b0000), .pending_o(m2_pend), .overflow_o(m2_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [2:0] fld(input logic [11:0] p, input int unsigned c);
    return p[c*3 +: 3];
  endfunction

  // Flip the selected channels and wait long enough for the event to be counted.
  task automatic toggle_mask(input logic [3:0] m);
    async_in = async_in ^ m;
    tick(4);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    async_in = '0;
    async_m  = '0;
    ready    = '0;
    tick(3);

    // Reset state
    check_eq("rst_sync",  {28'd0, sync_out}, 32'h0);
    check_eq("rst_valid", {28'd0, valid},    32'h0);
    check_eq("rst_pend",  {20'd0, pend},     32'h0);
    check_eq("rst_ovf",   {28'd0, ovf},      32'h0);
    rst_n = 1'b1;
    tick(2);
    check_eq("post_rst_pend", {20'd0, pend}, 32'h0);

    // Latency on ch0: sync at edge 2, counted at edge 3, single pop drains it
    async_in[0] = 1'b1;
    tick(1);
    check_eq("lat_sync_e1", {31'd0, sync_out[0]}, 32'd0);
    tick(1);
    check_eq("lat_sync_e2",  {31'd0, sync_out[0]}, 32'd1);
    check_eq("lat_valid_e2", {31'd0, valid[0]},    32'd0);
    tick(1);
    check_eq("lat_valid_e3", {31'd0, valid[0]},    32'd1);
    check_eq("lat_pend_e3",  {29'd0, fld(pend, 0)}, 32'd1);
    ready[0] = 1'b1;
    tick(1);
    ready[0] = 1'b0;
    check_eq("pop_pend",  {29'd0, fld(pend, 0)}, 32'd0);
    check_eq("pop_valid", {31'd0, valid[0]},     32'd0);

    // Saturation and sticky overflow on ch1
    for (int i = 0; i < 7; i++) toggle_mask(4'b0010);
    check_eq("sat7_pend", {29'd0, fld(pend, 1)}, 32'd7);
    check_eq("sat7_ovf",  {31'd0, ovf[1]},       32'd0);
    toggle_mask(4'b0010);
    check_eq("sat8_pend", {29'd0, fld(pend, 1)}, 32'd7);
    check_eq("sat8_ovf",  {31'd0, ovf[1]},       32'd1);
    ready[1] = 1'b1;
    tick(7);
    check_eq("drain_pend", {29'd0, fld(pend, 1)}, 32'd0);
    check_eq("drain_ovf",  {31'd0, ovf[1]},       32'd1);
    tick(1);
    ready[1] = 1'b0;
    check_eq("no_underflow", {29'd0, fld(pend, 1)}, 32'd0);
    do_clear();
    check_eq("clr_ovf", {31'd0, ovf[1]}, 32'd0);

    // Simultaneous event and pop on ch2
    toggle_mask(4'b0100);
    toggle_mask(4'b0100);
    check_eq("ch2_cnt2", {29'd0, fld(pend, 2)}, 32'd2);
    async_in[2] = ~async_in[2];
    tick(2);
    ready[2] = 1'b1;
    tick(1);
    ready[2] = 1'b0;
    check_eq("evtpop_cnt2", {29'd0, fld(pend, 2)}, 32'd2);
    tick(1);
    check_eq("evtpop_cnt2_hold", {29'd0, fld(pend, 2)}, 32'd2);
    for (int i = 0; i < 5; i++) toggle_mask(4'b0100);
    check_eq("ch2_cnt7", {29'd0, fld(pend, 2)}, 32'd7);
    async_in[2] = ~async_in[2];
    tick(2);
    ready[2] = 1'b1;
    tick(1);
    ready[2] = 1'b0;
    check_eq("evtpop_cnt7", {29'd0, fld(pend, 2)}, 32'd7);
    check_eq("evtpop_ovf",  {31'd0, ovf[2]},       32'd0);
    do_clear();

    // Edge modes on ch3: pulse 0->1->0
    async_in[3] = ~async_in[3];
    async_m[3]  = 1'b1;
    tick(4);
    check_eq("m1_rise", {29'd0, fld(m1_pend, 3)}, 32'd1);
    check_eq("m2_rise", {29'd0, fld(m2_pend, 3)}, 32'd0);
    async_in[3] = ~async_in[3];
    async_m[3]  = 1'b0;
    tick(4);
    check_eq("m0_pulse", {29'd0, fld(pend, 3)},    32'd2);
    check_eq("m1_pulse", {29'd0, fld(m1_pend, 3)}, 32'd1);
    check_eq("m2_pulse", {29'd0, fld(m2_pend, 3)}, 32'd1);
    do_clear();

    // All channels in the same cycle, then clear colliding with counting edge
    async_in = async_in ^ 4'hF;
    tick(3);
    check_eq("all_pend",  {20'd0, pend},  32'h249);
    check_eq("all_valid", {28'd0, valid}, 32'hF);
    tick(1);
    async_in = async_in ^ 4'hF;
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check_eq("clr_race_pend", {20'd0, pend}, 32'h0);
    check_eq("clr_race_ovf",  {28'd0, ovf},  32'h0);
    tick(1);
    check_eq("clr_race_after", {20'd0, pend}, 32'h0);

    // Build counts {3,1,0,5}, then asynchronous reset mid-cycle
    toggle_mask(4'b1011);
    toggle_mask(4'b1001);
    toggle_mask(4'b1001);
    toggle_mask(4'b1000);
    toggle_mask(4'b1000);
    check_eq("pre_rst_pend", {20'd0, pend}, 32'hA0B);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_pend",  {20'd0, pend},     32'h0);
    check_eq("arst_valid", {28'd0, valid},    32'h0);
    check_eq("arst_sync",  {28'd0, sync_out}, 32'h0);
    check_eq("arst_ovf",   {28'd0, ovf},      32'h0);
    async_in = 4'b0001;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_eq("rel_valid_e2", {28'd0, valid}, 32'h0);
    tick(1);
    check_eq("rel_pend_e3", {20'd0, pend}, 32'h001);
    tick(5);
    check_eq("rel_pend_hold",  {20'd0, pend},  32'h001);
    check_eq("rel_valid_hold", {28'd0, valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
